// File: rtl/systolic_output_collector_if.sv
// Bundle of the partial-sum capture bus and the result-vector handshake
// used by systolic_output_collector.
// The collector connects through the slave modport.
// The array/readout side, or a testbench, connects through the master modport.
interface systolic_output_collector_if #(
  parameter int WIDTH = 16,
  parameter int ROWS  = 4
);
  logic [ROWS*WIDTH-1:0] in_psum;
  logic [ROWS-1:0]       in_valid;
  logic [ROWS*WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_psum,
    output in_valid,
    output out_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  in_psum,
    input  in_valid,
    input  out_ready,
    output out_data,
    output out_valid
  );
endinterface

// File: rtl/systolic_output_collector.sv
// systolic_output_collector: deskews the per-row results leaving the right
// edge of the systolic array. Each row has its own FIFO lane. A full result
// vector is released through a valid/ready handshake once every lane holds
// at least one entry.
// Optional macro OUT_RELU_EN: when defined, each lane of out_data is clamped
// to max(value, 0) on the read path only. Stored values are not changed.
module systolic_output_collector #(
  parameter int WIDTH = 16,
  parameter int ROWS  = 4,
  parameter int DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  systolic_output_collector_if.slave    bus,
  output logic                          almost_full,
  output logic                          overflow,
  output logic [31:0]                   vec_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ROWS-1:0]       lane_nonempty;
  logic [ROWS-1:0]       lane_af_next;
  logic [ROWS-1:0]       lane_drop;
  logic [ROWS*WIDTH-1:0] lane_heads;
  logic                  pop;

  logic        overflow_q, overflow_d;
  logic        almost_full_q, almost_full_d;
  logic [31:0] vec_count_q, vec_count_d;

  // A vector exists only when every lane has data. Popping advances all lanes together.
  assign bus.out_valid = &lane_nonempty;
  assign pop           = bus.out_valid & bus.out_ready;
  assign bus.out_data  = bus.out_valid ? lane_heads : '0;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_lane
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             push_ok;
    logic [WIDTH-1:0] head;

    // Lane next state. A full lane still accepts a push when a pop frees a slot in the same cycle.
    always_comb begin
      full     = (count_q == CNT_W'(DEPTH));
      push_ok  = bus.in_valid[gi] & (~full | pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
      end
    end

    // Lane pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    // Lane storage. Contents are meaningless until written, so it has no reset.
    always_ff @(posedge clk) begin
      if (push_ok && !clear) mem_q[wr_ptr_q] <= bus.in_psum[gi*WIDTH +: WIDTH];
    end

    assign head              = mem_q[rd_ptr_q];
    assign lane_nonempty[gi] = (count_q != '0);
    assign lane_drop[gi]     = bus.in_valid[gi] & full & ~pop & ~clear;
    assign lane_af_next[gi]  = (count_d >= CNT_W'(DEPTH - 2));

`ifdef OUT_RELU_EN
    assign lane_heads[gi*WIDTH +: WIDTH] = head[WIDTH-1] ? '0 : head;
`else
    assign lane_heads[gi*WIDTH +: WIDTH] = head;
`endif
  end

  // Global flags and the popped-vector counter. Clear wins over everything else.
  always_comb begin
    overflow_d    = overflow_q | (|lane_drop);
    vec_count_d   = vec_count_q + 32'(pop);
    almost_full_d = |lane_af_next;
    if (clear) begin
      overflow_d  = 1'b0;
      vec_count_d = '0;
    end
  end

  // Global flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q    <= 1'b0;
      almost_full_q <= 1'b0;
      vec_count_q   <= '0;
    end else begin
      overflow_q    <= overflow_d;
      almost_full_q <= almost_full_d;
      vec_count_q   <= vec_count_d;
    end
  end

  assign overflow    = overflow_q;
  assign almost_full = almost_full_q;
  assign vec_count   = vec_count_q;

endmodule

// File: tb/tb_systolic_output_collector.sv
// Testbench for systolic_output_collector (WIDTH=16, ROWS=4, DEPTH=8).
// It runs a table of vectors, hand-written corner sequences, and randomized
// traffic. Expected values come from a queue-based reference model.
module tb_systolic_output_collector;
  localparam int W = 16;
  localparam int R = 4;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        almost_full, overflow;
  logic [31:0] vec_count;

  always #5 clk = ~clk;

  systolic_output_collector_if #(.WIDTH(W), .ROWS(R)) bus ();

  systolic_output_collector #(.WIDTH(W), .ROWS(R), .DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .bus         (bus.slave),
    .almost_full (almost_full),
    .overflow    (overflow),
    .vec_count   (vec_count)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model: one queue per lane ----------------
  logic [W-1:0] mq [R][$];
  logic         m_ovf;
  logic         m_af;
  logic [31:0]  m_vc;

  function automatic logic m_valid();
    logic v = 1'b1;
    for (int r = 0; r < R; r++) if (mq[r].size() == 0) v = 1'b0;
    return v;
  endfunction

  function automatic logic [63:0] m_data();
    logic [63:0] d = '0;
    logic [W-1:0] v;
    if (m_valid()) begin
      for (int r = 0; r < R; r++) begin
        v = mq[r][0];
`ifdef OUT_RELU_EN
        if ($signed(v) < 0) v = '0;
`endif
        d[r*W +: W] = v;
      end
    end
    return d;
  endfunction

  task automatic m_flush();
    for (int r = 0; r < R; r++) mq[r].delete();
    m_ovf = 1'b0;
    m_af  = 1'b0;
    m_vc  = '0;
  endtask

  // Apply one cycle of inputs at a negedge and advance the model at the posedge.
  // Return at the following negedge, where outputs are sampled.
  task automatic step(input logic [3:0] v, input logic [63:0] p, input logic rdy, input logic clr);
    logic do_pop;
    bus.in_valid  = v;
    bus.in_psum   = p;
    bus.out_ready = rdy;
    clear         = clr;
    do_pop = m_valid() && rdy;
    @(posedge clk);
    if (clr) begin
      m_flush();
    end else begin
      if (do_pop) begin
        for (int r = 0; r < R; r++) void'(mq[r].pop_front());
        m_vc++;
      end
      for (int r = 0; r < R; r++)
        if (v[r]) begin
          if (mq[r].size() < D) mq[r].push_back(p[r*W +: W]);
          else m_ovf = 1'b1;
        end
    end
    m_af = 1'b0;
    for (int r = 0; r < R; r++) if (mq[r].size() >= D - 2) m_af = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(m_valid()));
    chk({tag, "_data"},  bus.out_data, m_data());
    chk({tag, "_af"},    64'(almost_full), 64'(m_af));
    chk({tag, "_ovf"},   64'(overflow), 64'(m_ovf));
    chk({tag, "_vc"},    64'(vec_count), 64'(m_vc));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_data"},  bus.out_data, 64'd0);
    chk({tag, "_af"},    64'(almost_full), 64'd0);
    chk({tag, "_ovf"},   64'(overflow), 64'd0);
    chk({tag, "_vc"},    64'(vec_count), 64'd0);
  endtask

  task automatic do_reset();
    bus.in_valid  = '0;
    bus.in_psum   = '0;
    bus.out_ready = 1'b0;
    clear         = 1'b0;
    rst_n         = 1'b0;
    m_flush();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pattern vector k: lane r holds k*16 + r (all positive).
  function automatic logic [63:0] pat(input int k);
    logic [63:0] d;
    for (int r = 0; r < R; r++) d[r*W +: W] = 16'(k * 16 + r);
    return d;
  endfunction

  typedef struct {
    logic [3:0]  v;
    logic [63:0] p;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic [63:0] ed;
    logic        eaf;
    logic        eovf;
    logic [31:0] evc;
  } vec_t;

  localparam logic [63:0] RELU_IN = 64'h0000_8000_0007_FFFB;
`ifdef OUT_RELU_EN
  localparam logic [63:0] RELU_EXP = 64'h0000_0000_0007_0000;
`else
  localparam logic [63:0] RELU_EXP = RELU_IN;
`endif

  vec_t tbl [9];

  initial begin
    tbl[0] = '{4'h1, 64'hDEAD_DEAD_DEAD_000A, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 32'd0};
    tbl[1] = '{4'h2, 64'hDEAD_DEAD_000B_DEAD, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 32'd0};
    tbl[2] = '{4'h4, 64'hDEAD_000C_DEAD_DEAD, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 32'd0};
    tbl[3] = '{4'h8, 64'h000D_DEAD_DEAD_DEAD, 1'b1, 1'b0, 1'b1, 64'h000D_000C_000B_000A, 1'b0, 1'b0, 32'd0};
    tbl[4] = '{4'h0, 64'h0,                   1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 32'd1};
    tbl[5] = '{4'hF, RELU_IN,                 1'b0, 1'b0, 1'b1, RELU_EXP, 1'b0, 1'b0, 32'd1};
    tbl[6] = '{4'h0, 64'h0,                   1'b0, 1'b0, 1'b1, RELU_EXP, 1'b0, 1'b0, 32'd1};
    tbl[7] = '{4'hF, 64'h0001_0001_0001_0001, 1'b1, 1'b0, 1'b1, 64'h0001_0001_0001_0001, 1'b0, 1'b0, 32'd2};
    tbl[8] = '{4'h0, 64'h0,                   1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 32'd0};

    bus.in_valid  = '0;
    bus.in_psum   = '0;
    bus.out_ready = 1'b0;
    m_flush();

    // Reset state.
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Table: skewed fill, pop, ReLU lanes, hold under backpressure, clear.
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].p, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d_valid", i), 64'(bus.out_valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i),  bus.out_data, tbl[i].ed);
      chk($sformatf("tbl%0d_af", i),    64'(almost_full), 64'(tbl[i].eaf));
      chk($sformatf("tbl%0d_ovf", i),   64'(overflow), 64'(tbl[i].eovf));
      chk($sformatf("tbl%0d_vc", i),    64'(vec_count), 64'(tbl[i].evc));
    end

    // Backpressure: push 9 vectors with out_ready=0. The 9th push is dropped.
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      step(4'hF, pat(k), 1'b0, 1'b0);
      chk($sformatf("bp%0d_af", k),  64'(almost_full), 64'(k >= 6));
      chk($sformatf("bp%0d_ovf", k), 64'(overflow), 64'(k == 9));
    end
    chk("bp_head", bus.out_data, pat(1));
    check_model("bp_end");

    // Full lanes: a push and a pop in the same cycle, then a drain in FIFO order.
    step(4'h0, 64'h0, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) step(4'hF, pat(k), 1'b0, 1'b0);
    step(4'hF, pat(20), 1'b1, 1'b0);
    chk("fullpp_af",   64'(almost_full), 64'd1);
    chk("fullpp_ovf",  64'(overflow), 64'd0);
    chk("fullpp_vc",   64'(vec_count), 64'd1);
    chk("fullpp_head", bus.out_data, pat(2));
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("drain%0d_data", j), bus.out_data, (j < 7) ? pat(j + 2) : pat(20));
      step(4'h0, 64'h0, 1'b1, 1'b0);
    end
    chk("drain_valid", 64'(bus.out_valid), 64'd0);
    chk("drain_vc",    64'(vec_count), 64'd9);

    // Clear with 3 vectors buffered and overflow set.
    step(4'h0, 64'h0, 1'b0, 1'b1);
    for (int k = 1; k <= 9; k++) step(4'h1, pat(k), 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) step(4'hE, pat(30 + k), 1'b0, 1'b0);
    chk("preclr_valid", 64'(bus.out_valid), 64'd1);
    chk("preclr_ovf",   64'(overflow), 64'd1);
    step(4'h0, 64'h0, 1'b0, 1'b1);
    check_all_zero("postclr");

    // Reset mid-stream: outputs drop at once, and no partial vector appears afterwards.
    step(4'h0, 64'h0, 1'b0, 1'b1);
    for (int k = 1; k <= 7; k++) step(4'hF, pat(k), 1'b0, 1'b0);
    step(4'h0, 64'h0, 1'b1, 1'b0);
    check_model("premid");
    bus.in_valid = 4'hF;
    bus.in_psum  = pat(40);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    bus.in_valid = '0;
    m_flush();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'h1, pat(50), 1'b0, 1'b0);
    step(4'h2, pat(50), 1'b0, 1'b0);
    step(4'h4, pat(50), 1'b0, 1'b0);
    chk("rerst_partial_valid", 64'(bus.out_valid), 64'd0);
    chk("rerst_partial_data",  bus.out_data, 64'd0);
    step(4'h8, pat(50), 1'b0, 1'b0);
    chk("rerst_full_valid", 64'(bus.out_valid), 64'd1);
    chk("rerst_full_data",  bus.out_data, pat(50));

    // Randomized traffic checked against the model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      logic [3:0]  v;
      logic [63:0] p;
      for (int r = 0; r < R; r++) v[r] = ($urandom_range(0, 3) != 0);
      p = {$urandom(), $urandom()};
      step(v, p, 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
      check_model($sformatf("rnd%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
